// File: rtl/ccd_line_axis.sv
// ccd_line_axis: frames the raw AFE pixel stream into CCD lines, estimates the
// black level from the optical-black pixels, optionally subtracts it, and
// emits active pixels as AXI4-Stream video through a small FWFT FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for the first line_start
// S_LEAD   | dummy/OB lead pixels, OB window accumulated
// S_ACTIVE | active pixels pushed to the output FIFO
// S_DONE   | line complete, extra pixels ignored until line_start
module ccd_line_axis #(
    parameter int D_WIDTH     = 8,
    parameter int DUMMY_LEAD  = 32,
    parameter int OB_START    = 13,
    parameter int OB_LOG2     = 4,
    parameter int ACTIVE_PIX  = 2048,
    parameter int FRAME_LINES = 1024,
    parameter int FIFO_LOG2   = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               line_start,
    input  logic [D_WIDTH-1:0] in_tdata,
    input  logic               in_tvalid,
    input  logic               black_en,
    input  logic               status_clr,
    output logic [D_WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic [D_WIDTH-1:0] black_level,
    output logic [1:0]         status
);

    localparam int IW = $clog2(DUMMY_LEAD + ACTIVE_PIX) + 1;
    localparam int AW = D_WIDTH + OB_LOG2;
    localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int FD = 1 << FIFO_LOG2;
    localparam int EW = D_WIDTH + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LEAD   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [IW-1:0] LEAD_LAST = IW'(DUMMY_LEAD - 1);
    localparam logic [IW-1:0] ACT_FIRST = IW'(DUMMY_LEAD);
    localparam logic [IW-1:0] LINE_LAST = IW'(DUMMY_LEAD + ACTIVE_PIX - 1);
    localparam logic [IW-1:0] OB_FIRST  = IW'(OB_START);
    localparam logic [IW-1:0] OB_LAST   = IW'(OB_START + (1 << OB_LOG2) - 1);

    logic [1:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [AW-1:0]        r_acc;
    logic                 r_ob_done;
    logic [D_WIDTH-1:0]   r_black;
    logic [LW-1:0]        r_line;
    logic                 r_s_valid;
    logic [D_WIDTH-1:0]   r_s_data;
    logic                 r_s_last;
    logic                 r_s_user;
    logic [1:0]           r_status;
    logic [EW-1:0]        r_mem [FD];
    logic [FIFO_LOG2-1:0] r_wptr;
    logic [FIFO_LOG2-1:0] r_rptr;
    logic [FIFO_LOG2:0]   r_count;

    // line_start overrides the registered line context, so a pixel arriving
    // with it is treated as index 0 of the new line
    logic [1:0]         w_state_eff;
    logic [1:0]         w_state_nxt;
    logic [IW-1:0]      w_idx_eff;
    logic [AW-1:0]      w_acc_eff;
    logic               w_take;
    logic               w_in_ob;
    logic               w_act;
    logic               w_act_last;
    logic               w_short;
    logic [D_WIDTH:0]   w_diff;
    logic [D_WIDTH-1:0] w_pix;
    logic               w_full;
    logic               w_empty;
    logic               w_rd;
    logic               w_wr;
    logic               w_ovf;
    logic [EW-1:0]      w_head;

    assign w_state_eff = line_start ? S_LEAD : r_state;
    assign w_idx_eff   = line_start ? '0 : r_idx;
    assign w_acc_eff   = line_start ? '0 : r_acc;
    assign w_take      = in_tvalid && (w_state_eff == S_LEAD || w_state_eff == S_ACTIVE);
    assign w_in_ob     = (w_state_eff == S_LEAD) && (w_idx_eff >= OB_FIRST) && (w_idx_eff <= OB_LAST);
    assign w_act       = w_take && (w_state_eff == S_ACTIVE);
    assign w_act_last  = w_act && (w_idx_eff == LINE_LAST);
    assign w_short     = line_start && ((r_state == S_LEAD && r_idx != '0) || r_state == S_ACTIVE);

    assign w_diff = {1'b0, in_tdata} - {1'b0, r_black};
    assign w_pix  = !black_en ? in_tdata : (w_diff[D_WIDTH] ? '0 : w_diff[D_WIDTH-1:0]);

    // next-state decode from the effective (line_start-adjusted) state
    always_comb begin
        w_state_nxt = w_state_eff;
        if (w_take && w_state_eff == S_LEAD && w_idx_eff == LEAD_LAST)
            w_state_nxt = S_ACTIVE;
        if (w_act_last)
            w_state_nxt = S_DONE;
    end

    // line framing: state, pixel index, OB accumulation and black level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_ob_done <= 1'b0;
            r_black   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_take ? w_idx_eff + 1'b1 : w_idx_eff;
            r_acc     <= (w_take && w_in_ob) ? w_acc_eff + AW'(in_tdata) : w_acc_eff;
            r_ob_done <= w_take && w_in_ob && (w_idx_eff == OB_LAST);
            if (r_ob_done)
                r_black <= D_WIDTH'(r_acc >> OB_LOG2);
        end
    end

    // line counter advances only on a completed line
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_line <= '0;
        else if (w_act_last)
            r_line <= (r_line == LW'(FRAME_LINES - 1)) ? '0 : r_line + 1'b1;
    end

    // registered black subtraction stage feeding the FIFO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_last  <= 1'b0;
            r_s_user  <= 1'b0;
        end else begin
            r_s_valid <= w_act;
            if (w_act) begin
                r_s_data <= w_pix;
                r_s_last <= w_act_last;
                r_s_user <= (w_idx_eff == ACT_FIRST) && (r_line == '0);
            end
        end
    end

    assign w_full  = (r_count == (FIFO_LOG2 + 1)'(FD));
    assign w_empty = (r_count == '0);
    assign w_rd    = !w_empty && m_axis_tready;
    assign w_wr    = r_s_valid && (!w_full || w_rd);
    assign w_ovf   = r_s_valid && w_full && !w_rd;

    // FIFO storage; the head entry is not overwritten unless it is being read
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= {r_s_user, r_s_last, r_s_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd)
                r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // sticky status; a new event wins over a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_status <= '0;
        else
            r_status <= (status_clr ? 2'b00 : r_status) | {w_short, w_ovf};
    end

    assign w_head        = r_mem[r_rptr];
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_empty ? '0 : w_head[D_WIDTH-1:0];
    assign m_axis_tlast  = !w_empty && w_head[D_WIDTH];
    assign m_axis_tuser  = !w_empty && w_head[D_WIDTH+1];
    assign black_level   = r_black;
    assign status        = r_status;

endmodule

// File: tb/tb_ccd_line_axis.sv
// Directed bench for ccd_line_axis (FRAME_LINES reduced to 2 for frame wrap).
module tb_ccd_line_axis;

    logic       clk = 1'b0;
    logic       resetn;
    logic       line_start;
    logic [7:0] in_tdata;
    logic       in_tvalid;
    logic       black_en;
    logic       status_clr;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic [7:0] black_level;
    logic [1:0] status;

    int n_cmp = 0;
    int n_err = 0;

    int mon_beats, mon_last_cnt, mon_last_pos, mon_user_cnt, mon_user_pos;
    int mon_data_err, mon_stab_err;
    bit mon_clr = 1'b0;
    bit mon_chk = 1'b0;
    int mon_sub = 0;
    logic       prev_stall;
    logic [9:0] prev_word;

    ccd_line_axis #(.FRAME_LINES(2)) dut (
        .clk(clk), .resetn(resetn), .line_start(line_start),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .black_en(black_en),
        .status_clr(status_clr), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .black_level(black_level), .status(status)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_pix(input int k, input int sub);
        int v;
        v = k % 256;
        return (v > sub) ? 8'(v - sub) : 8'd0;
    endfunction

    // output monitor: beat counting, tlast/tuser positions, data and stability
    always @(negedge clk) begin
        if (mon_clr) begin
            mon_beats <= 0; mon_last_cnt <= 0; mon_last_pos <= 0;
            mon_user_cnt <= 0; mon_user_pos <= 0;
            mon_data_err <= 0; mon_stab_err <= 0;
            prev_stall <= 1'b0; prev_word <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                mon_beats <= mon_beats + 1;
                if (m_axis_tlast) begin
                    mon_last_cnt <= mon_last_cnt + 1;
                    mon_last_pos <= mon_beats + 1;
                end
                if (m_axis_tuser) begin
                    mon_user_cnt <= mon_user_cnt + 1;
                    mon_user_pos <= mon_beats + 1;
                end
                if (mon_chk && m_axis_tdata !== exp_pix(mon_beats, mon_sub))
                    mon_data_err <= mon_data_err + 1;
            end
            if (prev_stall && (!m_axis_tvalid ||
                {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_word))
                mon_stab_err <= mon_stab_err + 1;
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_word  <= {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic drive(input bit ls, input bit v, input logic [7:0] d, input bit rdy);
        @(posedge clk);
        #1;
        line_start    = ls;
        in_tvalid     = v;
        in_tdata      = d;
        m_axis_tready = rdy;
    endtask

    task automatic mon_clear();
        @(negedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // one line: line_start with lead pixel 0, 32 lead pixels, n_act active ramp
    // pixels; ob_kind 0 -> OB all 20, 1 -> OB 0..15; tready low for active
    // indices [sa, sa+sl)
    task automatic run_line(input int n_act, input int ob_kind, input int sa,
                            input int sl, input bit end_rdy);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            if (i >= 13 && i < 29) v = (ob_kind == 1) ? 8'(i - 13) : 8'd20;
            else                   v = 8'hA5;
            drive(i == 0, 1'b1, v, 1'b1);
        end
        for (int k = 0; k < n_act; k++)
            drive(1'b0, 1'b1, 8'(k % 256), !(k >= sa && k < sa + sl));
        drive(1'b0, 1'b0, 8'h00, end_rdy);
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b1);
        while (m_axis_tvalid && w < 300) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            w++;
        end
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain_timeout tvalid=%b expected 0", tag, m_axis_tvalid);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; line_start = 1'b0; in_tvalid = 1'b0; in_tdata = '0;
        black_en = 1'b1; status_clr = 1'b0; m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== 8'd0) begin n_err++; $display("FAIL reset_tdata got=%0d exp=0", m_axis_tdata); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
        n_cmp++; if (m_axis_tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser got=%b exp=0", m_axis_tuser); end
        n_cmp++; if (black_level !== 8'd0) begin n_err++; $display("FAIL reset_black got=%0d exp=0", black_level); end
        n_cmp++; if (status !== 2'b00) begin n_err++; $display("FAIL reset_status got=%b exp=00", status); end
        @(posedge clk);
        #1 resetn = 1'b1;
        mon_clear();
    endtask

    task automatic test_nominal();
        black_en = 1'b1; mon_chk = 1'b1; mon_sub = 20;
        mon_clear();
        run_line(2048, 0, -1, 0, 1'b1);
        drain("nominal");
        n_cmp++; if (mon_beats !== 2048) begin n_err++; $display("FAIL nominal_beats got=%0d exp=2048", mon_beats); end
        n_cmp++; if (mon_last_cnt !== 1) begin n_err++; $display("FAIL nominal_tlast_cnt got=%0d exp=1", mon_last_cnt); end
        n_cmp++; if (mon_last_pos !== 2048) begin n_err++; $display("FAIL nominal_tlast_pos got=%0d exp=2048", mon_last_pos); end
        n_cmp++; if (mon_user_cnt !== 1) begin n_err++; $display("FAIL nominal_tuser_cnt got=%0d exp=1", mon_user_cnt); end
        n_cmp++; if (mon_user_pos !== 1) begin n_err++; $display("FAIL nominal_tuser_pos got=%0d exp=1", mon_user_pos); end
        n_cmp++; if (mon_data_err !== 0) begin n_err++; $display("FAIL nominal_data_errors got=%0d exp=0", mon_data_err); end
        n_cmp++; if (black_level !== 8'd20) begin n_err++; $display("FAIL nominal_black got=%0d exp=20", black_level); end
        n_cmp++; if (status !== 2'b00) begin n_err++; $display("FAIL nominal_status got=%b exp=00", status); end
    endtask

    task automatic test_nonuniform_ob();
        black_en = 1'b0; mon_chk = 1'b1; mon_sub = 0;
        mon_clear();
        run_line(2048, 1, -1, 0, 1'b1);
        drain("ob_ramp");
        n_cmp++; if (black_level !== 8'd7) begin n_err++; $display("FAIL ob_ramp_black got=%0d exp=7", black_level); end
        n_cmp++; if (mon_data_err !== 0) begin n_err++; $display("FAIL ob_ramp_data_errors got=%0d exp=0", mon_data_err); end
        n_cmp++; if (mon_beats !== 2048) begin n_err++; $display("FAIL ob_ramp_beats got=%0d exp=2048", mon_beats); end
        n_cmp++; if (mon_user_cnt !== 0) begin n_err++; $display("FAIL ob_ramp_tuser_cnt got=%0d exp=0", mon_user_cnt); end
        black_en = 1'b1;
    endtask

    task automatic test_backpressure();
        // FIFO holds 1 entry in steady flow; 40 stalled writes fill 15 slots, drop 25
        black_en = 1'b1; mon_chk = 1'b0; mon_sub = 20;
        mon_clear();
        run_line(2048, 0, 500, 40, 1'b1);
        drain("bp");
        n_cmp++; if (mon_beats !== 2023) begin n_err++; $display("FAIL bp_beats got=%0d exp=2023", mon_beats); end
        n_cmp++; if (mon_last_cnt !== 1) begin n_err++; $display("FAIL bp_tlast_cnt got=%0d exp=1", mon_last_cnt); end
        n_cmp++; if (mon_last_pos !== 2023) begin n_err++; $display("FAIL bp_tlast_pos got=%0d exp=2023", mon_last_pos); end
        n_cmp++; if (mon_user_pos !== 1) begin n_err++; $display("FAIL bp_tuser_pos got=%0d exp=1", mon_user_pos); end
        n_cmp++; if (mon_stab_err !== 0) begin n_err++; $display("FAIL bp_axis_stability got=%0d exp=0", mon_stab_err); end
        n_cmp++; if (status !== 2'b01) begin n_err++; $display("FAIL bp_status got=%b exp=01", status); end
        @(posedge clk); #1 status_clr = 1'b1;
        @(posedge clk); #1 status_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (status !== 2'b00) begin n_err++; $display("FAIL bp_status_clr got=%b exp=00", status); end
    endtask

    task automatic test_short_line();
        black_en = 1'b1; mon_chk = 1'b1; mon_sub = 20;
        mon_clear();
        run_line(100, 0, -1, 0, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        n_cmp++; if (mon_beats !== 100) begin n_err++; $display("FAIL short_beats got=%0d exp=100", mon_beats); end
        n_cmp++; if (mon_last_cnt !== 0) begin n_err++; $display("FAIL short_tlast_cnt got=%0d exp=0", mon_last_cnt); end
        n_cmp++; if (mon_data_err !== 0) begin n_err++; $display("FAIL short_data_errors got=%0d exp=0", mon_data_err); end
        n_cmp++; if (status !== 2'b00) begin n_err++; $display("FAIL short_status_pre got=%b exp=00", status); end
        mon_clear();
        run_line(2048, 0, -1, 0, 1'b1);
        drain("short_next");
        n_cmp++; if (status !== 2'b10) begin n_err++; $display("FAIL short_status got=%b exp=10", status); end
        n_cmp++; if (mon_beats !== 2048) begin n_err++; $display("FAIL short_next_beats got=%0d exp=2048", mon_beats); end
        n_cmp++; if (mon_last_pos !== 2048) begin n_err++; $display("FAIL short_next_tlast_pos got=%0d exp=2048", mon_last_pos); end
        n_cmp++; if (mon_user_cnt !== 0) begin n_err++; $display("FAIL short_next_tuser_cnt got=%0d exp=0", mon_user_cnt); end
        @(posedge clk); #1 status_clr = 1'b1;
        @(posedge clk); #1 status_clr = 1'b0;
    endtask

    task automatic test_frame_wrap();
        int exp_user;
        black_en = 1'b1; mon_chk = 1'b1; mon_sub = 20;
        for (int l = 0; l < 3; l++) begin
            exp_user = (l == 1) ? 0 : 1;
            mon_clear();
            run_line(2048, 0, -1, 0, 1'b1);
            drain("wrap");
            n_cmp++; if (mon_user_cnt !== exp_user) begin n_err++; $display("FAIL wrap_tuser_line%0d got=%0d exp=%0d", l, mon_user_cnt, exp_user); end
            n_cmp++; if (mon_last_cnt !== 1) begin n_err++; $display("FAIL wrap_tlast_line%0d got=%0d exp=1", l, mon_last_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        black_en = 1'b1; mon_chk = 1'b0; mon_sub = 20;
        mon_clear();
        run_line(200, 0, 192, 100, 1'b0);
        @(negedge clk);
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_queued got=%b exp=1", m_axis_tvalid); end
        @(posedge clk); #1 resetn = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== 8'd0) begin n_err++; $display("FAIL rstmid_tdata got=%0d exp=0", m_axis_tdata); end
        n_cmp++; if (black_level !== 8'd0) begin n_err++; $display("FAIL rstmid_black got=%0d exp=0", black_level); end
        @(posedge clk); #1 resetn = 1'b1; m_axis_tready = 1'b1;
        mon_clear();
        for (int i = 0; i < 60; i++) drive(1'b0, 1'b1, 8'(i + 40), 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (mon_beats !== 0) begin n_err++; $display("FAIL rstmid_ignored_beats got=%0d exp=0", mon_beats); end
        mon_chk = 1'b1;
        mon_clear();
        run_line(2048, 0, -1, 0, 1'b1);
        drain("rstmid_next");
        n_cmp++; if (mon_beats !== 2048) begin n_err++; $display("FAIL rstmid_next_beats got=%0d exp=2048", mon_beats); end
        n_cmp++; if (mon_user_pos !== 1) begin n_err++; $display("FAIL rstmid_next_tuser_pos got=%0d exp=1", mon_user_pos); end
        n_cmp++; if (mon_data_err !== 0) begin n_err++; $display("FAIL rstmid_next_data_errors got=%0d exp=0", mon_data_err); end
        n_cmp++; if (mon_last_pos !== 2048) begin n_err++; $display("FAIL rstmid_next_tlast_pos got=%0d exp=2048", mon_last_pos); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_nonuniform_ob();
        test_backpressure();
        test_short_line();
        test_frame_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
